// File: rtl/pcap_fifo_to_axis.sv
// pcap_fifo_to_axis
// -----------------------------------------------------------------------------
// Per-queue packet framer. Reads records from one replay queue's
// first-word-fall-through FIFO and emits one AXI4-Stream packet per record.
// Each record is one header word followed by ceil(len/16) payload words.
// Records whose length is zero or above MAX_PKT_BYTES are dropped and counted.
//
// Optional feature macro: PCAP_REPLAY_DELAY_EN
//   defined     -> the header delay field is honoured by a GAP state and a
//                  32-bit gap counter before the payload is emitted.
//   not defined -> the delay field is ignored and HDR goes straight to PAYLOAD.
//
// Ports:
//   clk            single clock
//   rst            asynchronous active-high reset
//   sw_rst         synchronous soft reset, same effect as rst
//   enable         queue enable, sampled only in IDLE
//   fifo_dout      FWFT FIFO head word (bits [127:0] carry data)
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     FIFO pop strobe (combinational)
//   m_axis_tdata   stream data, byte 0 at [7:0]
//   m_axis_tkeep   byte enables
//   m_axis_tuser   [15:0] length, [23:16] source port, [31:24] DST_PORT
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   last beat of a packet
//   pkt_count      packets fully sent (wraps)
//   drop_count     records discarded (saturates)
// -----------------------------------------------------------------------------
module pcap_fifo_to_axis #(
  parameter int         FIFO_DATA_WIDTH      = 144,
  parameter int         C_M_AXIS_DATA_WIDTH  = 128,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         MAX_PKT_BYTES        = 9600,
  parameter logic [7:0] DST_PORT             = 8'h01
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sw_rst,
  input  logic                              enable,
  input  logic [FIFO_DATA_WIDTH-1:0]        fifo_dout,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_count,
  output logic [15:0]                       drop_count
);

  localparam int          KEEP_W   = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [16:0] MAX_LEN  = 17'(MAX_PKT_BYTES);
  localparam logic [15:0] BEAT_B   = 16'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_GAP,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [7:0]  src_reg, src_next;
  logic [15:0] bytes_left_reg, bytes_left_next;
  logic [31:0] pkt_count_reg, pkt_count_next;
  logic [15:0] drop_count_reg, drop_count_next;
`ifdef PCAP_REPLAY_DELAY_EN
  logic [31:0] gap_cnt_reg, gap_cnt_next;
`endif

  // Header field views of the FIFO head.
  logic [15:0] hdr_len;
  logic [7:0]  hdr_src;
  assign hdr_len = fifo_dout[15:0];
  assign hdr_src = fifo_dout[55:48];
`ifdef PCAP_REPLAY_DELAY_EN
  logic [31:0] hdr_delay;
  assign hdr_delay = fifo_dout[47:16];
`endif

  // FIFO sideband bits above the data field carry nothing for this block.
  generate
    if (FIFO_DATA_WIDTH > C_M_AXIS_DATA_WIDTH) begin : g_fifo_hi
      logic unused_fifo_hi;
      assign unused_fifo_hi = ^fifo_dout[FIFO_DATA_WIDTH-1:C_M_AXIS_DATA_WIDTH];
    end
  endgenerate

  // The last beat is decided from bytes_left before any subtraction, so the
  // counter never underflows.
  logic last_beat;
  assign last_beat = (bytes_left_reg <= BEAT_B);

  // Last-beat byte mask: lane gi is valid when more than gi bytes remain.
  // With 16 or more bytes left every lane is set, giving 16'hFFFF.
  logic [KEEP_W-1:0] keep_last;
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_keep
      assign keep_last[gi] = (bytes_left_reg > 16'(gi));
    end
  endgenerate

  // Packet sideband, constant for the whole packet.
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_pkt;
  always_comb begin
    tuser_pkt        = '0;
    tuser_pkt[15:0]  = len_reg;
    tuser_pkt[23:16] = src_reg;
    tuser_pkt[31:24] = DST_PORT;
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      src_reg        <= '0;
      bytes_left_reg <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
`ifdef PCAP_REPLAY_DELAY_EN
      gap_cnt_reg    <= '0;
`endif
    end else if (sw_rst) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      src_reg        <= '0;
      bytes_left_reg <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
`ifdef PCAP_REPLAY_DELAY_EN
      gap_cnt_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      src_reg        <= src_next;
      bytes_left_reg <= bytes_left_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
`ifdef PCAP_REPLAY_DELAY_EN
      gap_cnt_reg    <= gap_cnt_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    src_next        = src_reg;
    bytes_left_next = bytes_left_reg;
    pkt_count_next  = pkt_count_reg;
    drop_count_next = drop_count_reg;
`ifdef PCAP_REPLAY_DELAY_EN
    gap_cnt_next    = gap_cnt_reg;
`endif
    fifo_rd_en      = 1'b0;
    m_axis_tvalid   = 1'b0;
    m_axis_tdata    = '0;
    m_axis_tkeep    = '0;
    m_axis_tuser    = '0;
    m_axis_tlast    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!fifo_empty) begin
          fifo_rd_en      = 1'b1;
          len_next        = hdr_len;
          src_next        = hdr_src;
          bytes_left_next = hdr_len;
          if (hdr_len == 16'd0) begin
            // Empty record: nothing follows the header.
            if (drop_count_reg != 16'hFFFF) drop_count_next = drop_count_reg + 16'd1;
            state_next = ST_IDLE;
          end else if ({1'b0, hdr_len} > MAX_LEN) begin
            // Oversized record: its payload words still sit in the FIFO and
            // must be consumed silently.
            if (drop_count_reg != 16'hFFFF) drop_count_next = drop_count_reg + 16'd1;
            state_next = ST_DROP;
          end
`ifdef PCAP_REPLAY_DELAY_EN
          else if (hdr_delay != 32'd0) begin
            gap_cnt_next = hdr_delay;
            state_next   = ST_GAP;
          end
`endif
          else begin
            state_next = ST_PAYLOAD;
          end
        end
      end

`ifdef PCAP_REPLAY_DELAY_EN
      ST_GAP: begin
        // GAP lasts exactly 'delay' cycles: the counter is checked for 1
        // before decrementing.
        if (gap_cnt_reg <= 32'd1) begin
          state_next = ST_PAYLOAD;
        end else begin
          gap_cnt_next = gap_cnt_reg - 32'd1;
        end
      end
`endif

      ST_PAYLOAD: begin
        // The FWFT head is presented directly; it cannot change without a
        // pop, so stalled beats stay stable.
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_dout[C_M_AXIS_DATA_WIDTH-1:0];
        m_axis_tuser  = tuser_pkt;
        m_axis_tlast  = last_beat;
        m_axis_tkeep  = last_beat ? keep_last : {KEEP_W{1'b1}};
        fifo_rd_en    = m_axis_tvalid && m_axis_tready;
        if (fifo_rd_en) begin
          if (last_beat) begin
            pkt_count_next = pkt_count_reg + 32'd1;
            state_next     = ST_IDLE;
          end else begin
            bytes_left_next = bytes_left_reg - BEAT_B;
          end
        end
      end

      ST_DROP: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          if (last_beat) begin
            state_next = ST_IDLE;
          end else begin
            bytes_left_next = bytes_left_reg - BEAT_B;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pcap_fifo_to_axis.sv
// tb_pcap_fifo_to_axis
// Directed bench for pcap_fifo_to_axis: a FWFT FIFO model feeds records,
// a negedge monitor captures every stream handshake, and directed checks
// compare captured beats and counters with hand-computed values.
module tb_pcap_fifo_to_axis;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sw_rst = 1'b0;
  logic         enable = 1'b0;
  logic [143:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [31:0]  pkt_count;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  pcap_fifo_to_axis dut (
    .clk           (clk),
    .rst           (rst),
    .sw_rst        (sw_rst),
    .enable        (enable),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  // ---------------------------------------------------------------- FIFO model
  localparam int FDEPTH = 2048;
  logic [143:0] fmem [FDEPTH];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pops = 0;
  int   bad_pops = 0;
  int   cyc = 0;
  logic flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = fmem[rd_ptr % FDEPTH];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      else begin
        rd_ptr <= rd_ptr + 1;
        pops   <= pops + 1;
      end
    end
  end

  // ------------------------------------------------------------ beat monitor
  logic [127:0] bd [256];
  logic [15:0]  bk [256];
  logic         bl [256];
  logic [127:0] bu [256];
  int           bc [256];
  int           beat_n = 0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready && beat_n < 256) begin
      bd[beat_n] <= m_axis_tdata;
      bk[beat_n] <= m_axis_tkeep;
      bl[beat_n] <= m_axis_tlast;
      bu[beat_n] <= m_axis_tuser;
      bc[beat_n] <= cyc;
      beat_n     <= beat_n + 1;
    end
  end

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ----------------------------------------------------------------- helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [143:0] w);
    fmem[wr_ptr % FDEPTH] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Ignored header bits are filled with a pattern so that only the real
  // fields can influence the result.
  function automatic logic [143:0] hdr(input logic [15:0] len, input logic [31:0] dly,
                                       input logic [7:0] src);
    return {16'hFFFF, 72'hA5A5A5A5A5A5A5A5A5, src, dly, len};
  endfunction

  function automatic logic [143:0] pay(input int rec, input int i);
    return {16'hDEAD, 8'(rec), 8'(i), 112'h0123456789ABCDEF001122334455};
  endfunction

  task automatic send(input int rec, input logic [15:0] len, input logic [31:0] dly,
                      input logic [7:0] src, input int nw, output int pcyc, output int base);
    base = beat_n;
    pcyc = cyc;
    push(hdr(len, dly, src));
    for (int i = 0; i < nw; i++) push(pay(rec, i));
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && beat_n < target; i++) @(negedge clk);
    check(tag, 128'(beat_n >= target), 128'd1);
  endtask

  task automatic check_pkt(input string tag, input int base, input int rec, input int n,
                           input logic [15:0] len, input logic [7:0] src,
                           input logic [15:0] last_keep);
    logic [143:0] w;
    logic [127:0] user_exp;
    user_exp = {96'h0, 8'h01, src, len};
    for (int k = 0; k < n; k++) begin
      w = pay(rec, k);
      check($sformatf("%s_data%0d", tag, k), bd[base+k], w[127:0]);
      check($sformatf("%s_last%0d", tag, k), 128'(bl[base+k]), 128'(k == n - 1));
      check($sformatf("%s_keep%0d", tag, k), 128'(bk[base+k]),
            (k == n - 1) ? 128'(last_keep) : 128'h0000_FFFF);
      check($sformatf("%s_user%0d", tag, k), bu[base+k], user_exp);
    end
    $display("PKT %s rec %0d len %0d beats %0d first_cyc %0d", tag, rec, len, n, bc[base]);
  endtask

  // -------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int pc, b, p0, e0;
    logic [127:0] s1, s2;
    logic [143:0] w;

    // Reset state
    tick(3);
    check("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("rst_rd_en", 128'(fifo_rd_en), 128'd0);
    check("rst_pkt", 128'(pkt_count), 128'd0);
    check("rst_drop", 128'(drop_count), 128'd0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_tuser", m_axis_tuser, 128'd0);
    check("rst_tkeep", 128'(m_axis_tkeep), 128'd0);
    check("rst_tlast", 128'(m_axis_tlast), 128'd0);
    rst = 1'b0;
    tick(2);

    // Record 1 queued while disabled: nothing may be popped until enable.
    send(1, 16'd64, 32'd0, 8'h03, 4, pc, b);
    tick(3);
    check("disabled_pops", 128'(pops), 128'd0);
    check("disabled_tvalid", 128'(m_axis_tvalid), 128'd0);
    enable = 1'b1;
    e0 = cyc;
    wait_beats("t1_done", b + 4, 50);
    check_pkt("t1", b, 1, 4, 16'd64, 8'h03, 16'hFFFF);
    check("t1_first_cyc", 128'(bc[b] - e0), 128'd2);
    check("t1_span", 128'(bc[b+3] - bc[b]), 128'd3);
    tick(2);
    check("t1_pkt", 128'(pkt_count), 128'd1);
    check("t1_pops", 128'(pops), 128'd5);

    // len=61: partial last beat
    send(2, 16'd61, 32'd0, 8'h05, 4, pc, b);
    wait_beats("t2_done", b + 4, 50);
    check_pkt("t2", b, 2, 4, 16'd61, 8'h05, 16'h1FFF);
    check("t2_first_cyc", 128'(bc[b] - pc), 128'd1);
    tick(2);
    check("t2_pkt", 128'(pkt_count), 128'd2);

    // len=60, delay=10
    send(3, 16'd60, 32'd10, 8'h07, 4, pc, b);
    wait_beats("t3_done", b + 4, 80);
    check_pkt("t3", b, 3, 4, 16'd60, 8'h07, 16'h0FFF);
`ifdef PCAP_REPLAY_DELAY_EN
    check("t3_first_cyc", 128'(bc[b] - pc), 128'd11);
`else
    check("t3_first_cyc", 128'(bc[b] - pc), 128'd1);
`endif
    tick(2);
    check("t3_pkt", 128'(pkt_count), 128'd3);

    // tready 1,0,0,1 during a 4-beat packet
    p0 = pops;
    send(4, 16'd64, 32'd0, 8'h09, 4, pc, b);
    tick(1);
    tick(1);
    m_axis_tready = 1'b0;
    @(negedge clk);
    s1 = m_axis_tdata;
    check("t4_stall_valid", 128'(m_axis_tvalid), 128'd1);
    tick(1);
    @(negedge clk);
    s2 = m_axis_tdata;
    tick(1);
    m_axis_tready = 1'b1;
    w = pay(4, 1);
    check("t4_stall_head", s1, w[127:0]);
    check("t4_stall_hold", s2, w[127:0]);
    wait_beats("t4_done", b + 4, 50);
    tick(4);
    check_pkt("t4", b, 4, 4, 16'd64, 8'h09, 16'hFFFF);
    check("t4_beats", 128'(beat_n - b), 128'd4);
    check("t4_pops", 128'(pops - p0), 128'd5);
    check("t4_pkt", 128'(pkt_count), 128'd4);

    // Oversized record followed by a valid one
    p0 = pops;
    send(5, 16'd9601, 32'd0, 8'h02, 601, pc, b);
    push(hdr(16'd64, 32'd0, 8'h03));
    for (int i = 0; i < 4; i++) push(pay(6, i));
    wait_beats("t5_done", b + 4, 800);
    tick(4);
    check_pkt("t5", b, 6, 4, 16'd64, 8'h03, 16'hFFFF);
    check("t5_beats", 128'(beat_n - b), 128'd4);
    check("t5_drop", 128'(drop_count), 128'd1);
    check("t5_pops", 128'(pops - p0), 128'd607);
    check("t5_pkt", 128'(pkt_count), 128'd5);

    // len=0 header: counted as dropped, nothing popped after it
    p0 = pops;
    b = beat_n;
    push(hdr(16'd0, 32'd0, 8'h01));
    tick(10);
    check("t6_drop", 128'(drop_count), 128'd2);
    check("t6_pops", 128'(pops - p0), 128'd1);
    check("t6_beats", 128'(beat_n - b), 128'd0);
    $display("DROP len 0 drop_count %0d", drop_count);

    // Boundary lengths: exactly one full beat, and one byte past it
    send(7, 16'd16, 32'd0, 8'h04, 1, pc, b);
    wait_beats("t7_done", b + 1, 50);
    check_pkt("t7", b, 7, 1, 16'd16, 8'h04, 16'hFFFF);
    tick(2);
    send(8, 16'd17, 32'd0, 8'h04, 2, pc, b);
    wait_beats("t8_done", b + 2, 50);
    check_pkt("t8", b, 8, 2, 16'd17, 8'h04, 16'h0001);
    tick(2);
    check("t8_pkt", 128'(pkt_count), 128'd7);

    // Asynchronous reset mid-PAYLOAD
    m_axis_tready = 1'b0;
    send(9, 16'd64, 32'd0, 8'h01, 4, pc, b);
    tick(3);
    check("t9_pre_valid", 128'(m_axis_tvalid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t9_rst_valid", 128'(m_axis_tvalid), 128'd0);
    check("t9_rst_rd_en", 128'(fifo_rd_en), 128'd0);
    check("t9_rst_pkt", 128'(pkt_count), 128'd0);
    check("t9_rst_drop", 128'(drop_count), 128'd0);
    check("t9_rst_tuser", m_axis_tuser, 128'd0);
    $display("RST async mid-packet rec 9");
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    tick(3);
    check("t9_post_valid", 128'(m_axis_tvalid), 128'd0);
    send(10, 16'd32, 32'd0, 8'h06, 2, pc, b);
    wait_beats("t10_done", b + 2, 50);
    check_pkt("t10", b, 10, 2, 16'd32, 8'h06, 16'hFFFF);
    tick(2);
    check("t10_pkt", 128'(pkt_count), 128'd1);

    // Synchronous soft reset mid-PAYLOAD
    m_axis_tready = 1'b0;
    send(11, 16'd64, 32'd0, 8'h01, 4, pc, b);
    tick(3);
    sw_rst = 1'b1;
    #2;
    check("t11_before_edge", 128'(m_axis_tvalid), 128'd1);
    tick(1);
    check("t11_sw_valid", 128'(m_axis_tvalid), 128'd0);
    check("t11_sw_pkt", 128'(pkt_count), 128'd0);
    check("t11_sw_tuser", m_axis_tuser, 128'd0);
    $display("RST sw_rst mid-packet rec 11");
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    sw_rst = 1'b0;
    m_axis_tready = 1'b1;
    tick(3);
    check("t11_post_valid", 128'(m_axis_tvalid), 128'd0);

    check("rd_en_while_empty", 128'(bad_pops), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
